// File: rtl/readout_arb_if.sv
// Output-word stream of readout_arb: FIFO head, valid/ready handshake and full flag.
interface readout_arb_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 21
);
  logic [ADDR_W+DATA_W-1:0] DataOut;
  logic                     DataValid;
  logic                     DataReady;
  logic                     Full;

  modport master (
    output DataOut,
    output DataValid,
    output Full,
    input  DataReady
  );

  modport slave (
    input  DataOut,
    input  DataValid,
    input  Full,
    output DataReady
  );
endinterface

// File: rtl/readout_arb.sv
// Round-robin column readout arbiter feeding a first-word-fall-through output FIFO.
// Optional test-pattern data source is built when READOUT_ARB_TESTPAT_EN is defined.
module readout_arb #(
  parameter int unsigned NCOL   = 56,
  parameter int unsigned DATA_W = 21,
  parameter int unsigned BCID_W = 6,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   ClkBx,
  input  logic                   Reset,
  input  logic [BCID_W-1:0]      Bcid,
  input  logic [NCOL-1:0]        Enable,
  input  logic [NCOL-1:0]        TokColB,
  input  logic [NCOL*DATA_W-1:0] DataCol,
`ifdef READOUT_ARB_TESTPAT_EN
  input  logic                   EnTestPattern,
`endif
  output logic [NCOL-1:0]        ReadCol,
  output logic [NCOL-1:0]        FreezeCol,
  output logic [NCOL*BCID_W-1:0] BcidCol,
  readout_arb_if.master          rdout
);
  localparam int unsigned ADDR_W = $clog2(NCOL);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned WORD_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {IDLE, ARB, READ, LATCH} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      sel_q, sel_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic [ADDR_W-1:0]      pick;
  logic                   pick_found;
  logic [NCOL-1:0]        pend;
  logic [NCOL-1:0]        readcol_q, readcol_d;
  logic [NCOL*BCID_W-1:0] bcid_q;
  logic [DATA_W-1:0]      col_data;
  logic [DATA_W-1:0]      push_data;
  logic                   push, pop, full, empty;
  logic [WORD_W-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]       wptr_q, rptr_q;
  logic [PTR_W:0]         cnt_q, cnt_d;

  assign pend = ~TokColB & Enable;

  // First pending column strictly after the pointer, wrapping at NCOL-1.
  always_comb begin : rr_pick
    logic [ADDR_W-1:0] idx;
    idx        = '0;
    pick       = ptr_q;
    pick_found = 1'b0;
    for (int unsigned k = 1; k <= NCOL; k++) begin
      idx = ADDR_W'((32'(ptr_q) + k) % NCOL);
      if (!pick_found && pend[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    readcol_d = '0;
    case (state_q)
      IDLE: begin
        if (|pend) state_d = ARB;
      end
      ARB: begin
        if (!(|pend)) begin
          state_d = IDLE;
        end else if (!full) begin
          sel_d   = pick;
          ptr_d   = pick;
          state_d = READ;
        end
      end
      READ:    state_d = LATCH;
      LATCH:   state_d = ARB;
      default: state_d = IDLE;
    endcase
    if (state_d == READ) readcol_d[sel_d] = 1'b1;
  end

  always_comb begin
    col_data = '0;
    for (int unsigned c = 0; c < NCOL; c++) begin
      if (ADDR_W'(c) == sel_q) col_data = DataCol[c*DATA_W +: DATA_W];
    end
  end

`ifdef READOUT_ARB_TESTPAT_EN
  logic [DATA_W-1:0] tp_cnt_q;

  always_ff @(posedge ClkBx) begin
    if (Reset) begin
      tp_cnt_q <= '0;
    end else if (push) begin
      tp_cnt_q <= tp_cnt_q + DATA_W'(1);
    end
  end

  assign push_data = EnTestPattern ? tp_cnt_q : col_data;
`else
  assign push_data = col_data;
`endif

  // The word is captured on the edge that enters LATCH, one cycle after the
  // strobe, so it is already visible on DataOut during the LATCH cycle.
  assign push  = (state_q == READ);
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign pop   = !empty && rdout.DataReady;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ClkBx) begin
    if (push) mem_q[wptr_q] <= {sel_q, push_data};
  end

  always_ff @(posedge ClkBx) begin
    if (Reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= ADDR_W'(NCOL - 1);
      readcol_q <= '0;
      bcid_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      readcol_q <= readcol_d;
      bcid_q    <= {NCOL{Bcid}};
      cnt_q     <= cnt_d;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  assign ReadCol         = readcol_q;
  assign FreezeCol       = (state_q != IDLE) ? Enable : '0;
  assign BcidCol         = bcid_q;
  assign rdout.DataOut   = empty ? '0 : mem_q[rptr_q];
  assign rdout.DataValid = !empty;
  assign rdout.Full      = full;

  a_no_overflow: assert property (@(posedge ClkBx) disable iff (Reset)
    !(push && full && !pop));
  a_onehot_read: assert property (@(posedge ClkBx) disable iff (Reset)
    $onehot0(ReadCol));
endmodule

// File: tb/tb_readout_arb.sv
// Directed bench for readout_arb: hit latency, round-robin order, masking,
// backpressure, reset mid-read and (when built with the macro) test pattern.
module tb_readout_arb;
  localparam int NCOL = 56;
  localparam int DW   = 21;
  localparam int BW   = 6;
  localparam int AW   = 6;

  logic              ClkBx;
  logic              Reset;
  logic [BW-1:0]     Bcid;
  logic [NCOL-1:0]   Enable;
  logic [NCOL-1:0]   TokColB;
  logic [NCOL*DW-1:0] DataCol;
  logic [NCOL-1:0]   ReadCol;
  logic [NCOL-1:0]   FreezeCol;
  logic [NCOL*BW-1:0] BcidCol;
`ifdef READOUT_ARB_TESTPAT_EN
  logic              EnTestPattern;
`endif

  readout_arb_if #(.ADDR_W(AW), .DATA_W(DW)) rd_if ();

  readout_arb #(
    .NCOL  (NCOL),
    .DATA_W(DW),
    .BCID_W(BW),
    .DEPTH (4)
  ) dut (
    .ClkBx        (ClkBx),
    .Reset        (Reset),
    .Bcid         (Bcid),
    .Enable       (Enable),
    .TokColB      (TokColB),
    .DataCol      (DataCol),
`ifdef READOUT_ARB_TESTPAT_EN
    .EnTestPattern(EnTestPattern),
`endif
    .ReadCol      (ReadCol),
    .FreezeCol    (FreezeCol),
    .BcidCol      (BcidCol),
    .rdout        (rd_if)
  );

  initial ClkBx = 1'b0;
  always #5 ClkBx = ~ClkBx;

  int checks = 0;
  int errors = 0;
  int strobes_q[$];
  logic [AW+DW-1:0] got_q[$];
  logic auto_rel = 1'b1;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int c);
    return (c == 3) ? 21'h1ABCD : (21'h0F000 | 21'(c));
  endfunction

  function automatic logic [AW+DW-1:0] word(input int c, input logic [DW-1:0] d);
    return {6'(c), d};
  endfunction

  // One clock: log the pop that happens at this edge, then sample #1 after it
  // and let each strobed column drop its token (column behaviour).
  task automatic tick();
    if (rd_if.DataValid && rd_if.DataReady) got_q.push_back(rd_if.DataOut);
    @(posedge ClkBx);
    #1;
    for (int c = 0; c < NCOL; c++) begin
      if (ReadCol[c]) begin
        strobes_q.push_back(c);
        if (auto_rel) TokColB[c] = 1'b1;
      end
    end
  endtask

  task automatic clear_logs();
    strobes_q.delete();
    got_q.delete();
  endtask

  initial begin
    logic [NCOL-1:0] oh;
    logic ok;
    int rr_exp[3];
    int bp_cols[6];
    rr_exp  = '{7, 0, 3};
    bp_cols = '{20, 21, 30, 40, 50, 55};

    Reset   = 1'b1;
    Bcid    = '0;
    Enable  = '1;
    TokColB = '1;
    rd_if.DataReady = 1'b0;
`ifdef READOUT_ARB_TESTPAT_EN
    EnTestPattern = 1'b0;
`endif
    for (int c = 0; c < NCOL; c++) DataCol[c*DW +: DW] = pat(c);

    tick();
    tick();
    chk("rst_readcol", ReadCol, 0);
    chk("rst_freeze", FreezeCol, 0);
    chk("rst_bcidcol", BcidCol, 0);
    chk("rst_dataout", rd_if.DataOut, 0);
    chk("rst_valid", rd_if.DataValid, 0);
    chk("rst_full", rd_if.Full, 0);
    Reset = 1'b0;

    Bcid = 6'h2A;
    tick();
    chk("bcid_repl", BcidCol, {NCOL{6'h2A}});

    // Single hit on column 3
    clear_logs();
    TokColB[3] = 1'b0;
    tick();
    chk("hit_freeze_rise", FreezeCol, Enable);
    chk("hit_no_strobe_arb", ReadCol, 0);
    tick();
    oh = 56'd1 << 3;
    chk("hit_strobe", ReadCol, oh);
    tick();
    chk("hit_strobe_1cyc", ReadCol, 0);
    chk("hit_valid", rd_if.DataValid, 1);
    chk("hit_dataout", rd_if.DataOut, {6'd3, 21'h1ABCD});
    tick();
    chk("hit_freeze_arb", FreezeCol, Enable);
    tick();
    chk("hit_freeze_fall", FreezeCol, 0);
    rd_if.DataReady = 1'b1;
    tick();
    chk("hit_popped", rd_if.DataValid, 0);

    // Move the pointer to 5, then columns 0, 3, 7 together
    TokColB[5] = 1'b0;
    repeat (6) tick();
    clear_logs();
    TokColB[0] = 1'b0;
    TokColB[3] = 1'b0;
    TokColB[7] = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      tick();
      if (FreezeCol !== Enable) ok = 1'b0;
    end
    chk("rr_freeze_held", ok, 1);
    repeat (3) tick();
    chk("rr_count", strobes_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rr_col%0d", i), strobes_q[i], rr_exp[i]);
      chk($sformatf("rr_word%0d", i), got_q[i], word(rr_exp[i], pat(rr_exp[i])));
    end
    chk("rr_freeze_end", FreezeCol, 0);

    // Disabled column is ignored
    clear_logs();
    Enable[10]  = 1'b0;
    TokColB[10] = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (ReadCol !== 0 || FreezeCol !== 0 || rd_if.DataValid !== 1'b0) ok = 1'b0;
    end
    chk("mask_quiet", ok, 1);
    TokColB[10] = 1'b1;
    Enable[10]  = 1'b1;

    // Backpressure: six pending, FIFO of four
    clear_logs();
    rd_if.DataReady = 1'b0;
    foreach (bp_cols[i]) TokColB[bp_cols[i]] = 1'b0;
    repeat (20) tick();
    chk("bp_strobes_parked", strobes_q.size(), 4);
    chk("bp_full", rd_if.Full, 1);
    chk("bp_valid", rd_if.DataValid, 1);
    chk("bp_freeze_arb", FreezeCol, Enable);
    chk("bp_no_strobe", ReadCol, 0);
    rd_if.DataReady = 1'b1;
    repeat (30) tick();
    chk("bp_strobes_total", strobes_q.size(), 6);
    chk("bp_words_total", got_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_word%0d", i), got_q[i], word(bp_cols[i], pat(bp_cols[i])));
    end
    chk("bp_full_clear", rd_if.Full, 0);
    chk("bp_drained", rd_if.DataValid, 0);

    // Reset in the READ cycle with a word already queued
    rd_if.DataReady = 1'b0;
    TokColB[20] = 1'b0;
    repeat (5) tick();
    chk("rmr_pre_valid", rd_if.DataValid, 1);
    auto_rel = 1'b0;
    TokColB[0]  = 1'b0;
    TokColB[30] = 1'b0;
    tick();
    tick();
    oh = 56'd1 << 30;
    chk("rmr_strobe30", ReadCol, oh);
    Reset = 1'b1;
    tick();
    chk("rmr_readcol", ReadCol, 0);
    chk("rmr_freeze", FreezeCol, 0);
    chk("rmr_bcidcol", BcidCol, 0);
    chk("rmr_dataout", rd_if.DataOut, 0);
    chk("rmr_valid", rd_if.DataValid, 0);
    chk("rmr_full", rd_if.Full, 0);
    Reset = 1'b0;
    auto_rel = 1'b1;
    rd_if.DataReady = 1'b1;
    clear_logs();
    repeat (10) tick();
    chk("rmr_strobe_count", strobes_q.size(), 2);
    chk("rmr_first_col0", strobes_q[0], 0);
    chk("rmr_second_col30", strobes_q[1], 30);
    chk("rmr_word_count", got_q.size(), 2);
    chk("rmr_word0", got_q[0], word(0, pat(0)));

`ifdef READOUT_ARB_TESTPAT_EN
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    EnTestPattern = 1'b1;
    clear_logs();
    repeat (3) begin
      TokColB[2] = 1'b0;
      repeat (6) tick();
    end
    chk("tp_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tp_word%0d", i), got_q[i], word(2, 21'(i)));
    end
    EnTestPattern = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
